instr_fetch_ctrl: RTL
=====================

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the prefetch queue entries (power of two, at least 2).
REQ-002 The block SHALL have parameter MEM_BYTES, default 1024, giving the instruction memory size in bytes.
REQ-003 The block SHALL have parameter RESET_PC, default 64'h0, giving the first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 imem_addr  output  64  byte address presented to the combinational instruction memory.
REQ-007 imem_instr  input  32  instruction returned by the memory for imem_addr in the same cycle.
REQ-008 redirect_valid  input  1  taken branch or flush request from the pipeline.
REQ-009 redirect_pc  input  64  target byte address accompanying redirect_valid.
REQ-010 halt_req  input  1  level request to pause fetching.
REQ-011 out_valid  output  1  head queue entry is valid.
REQ-012 out_ready  input  1  decode accepts the head entry this cycle.
REQ-013 out_instr, out_pc  output  32, 64  head entry instruction and its byte address.
REQ-014 fault  output  1  sticky out-of-range fetch indication (see Configuration).

Function
REQ-015 imem_addr SHALL equal the fetch_pc register combinationally, with bits [1:0] always 0.
REQ-016 The FSM SHALL have states FETCH, FULL, PAUSE and FAULT, with FETCH entered on reset.
REQ-017 In FETCH, each cycle with queue space (count < DEPTH, or count == DEPTH with a pop in the same cycle), the block SHALL push {fetch_pc, imem_instr} and advance fetch_pc by 4, modulo 2^64.
REQ-018 FETCH SHALL go to FULL when count reaches DEPTH with no pop, and FULL SHALL return to FETCH on the first pop, with no fetch in the FULL cycle.
REQ-019 A pop SHALL occur exactly when out_valid && out_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-020 out_valid SHALL be 1 exactly when count > 0; out_instr and out_pc SHALL be the head entry and SHALL stay stable while out_valid && !out_ready.
REQ-021 Fetch-to-output latency SHALL be 1 cycle: an entry pushed at edge N is visible on the outputs after edge N.
REQ-022 halt_req high SHALL suppress pushes and move the FSM to PAUSE; halt_req low SHALL return the FSM to FETCH or FULL by count; pops SHALL continue in PAUSE.
REQ-023 redirect_valid SHALL have priority over push, pop and halt: the queue is flushed (count 0), fetch_pc <= {redirect_pc[63:2], 2'b00}, no push or pop occurs, and FULL or FAULT returns to FETCH (PAUSE remains if halt_req is high).
REQ-024 After a redirect, out_valid SHALL be 0 in the following cycle, and the target instruction SHALL appear one cycle later.
REQ-025 Queue pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits and never exceed DEPTH.

Reset
REQ-026 With reset_n low at a rising edge: fetch_pc <= RESET_PC, count and pointers <= 0, FSM <= FETCH, fault <= 0, out_valid = 0; reset SHALL override redirect and halt.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries with no partial output on the following cycle; the queue data storage needs no reset.

Configuration
REQ-028 With FETCH_BOUNDS_CHECK_EN defined, a push attempt with fetch_pc + 3 >= MEM_BYTES SHALL NOT push, SHALL set fault, and SHALL enter FAULT; FAULT stops fetching but drains the queue, and only redirect or reset leaves it (reset clears fault, redirect does not).
REQ-029 Without FETCH_BOUNDS_CHECK_EN, fault SHALL be tied to 0, no FAULT state SHALL exist, and fetching SHALL proceed past MEM_BYTES unchecked.

Verification
REQ-030 Reset release, out_ready=1, mem[i]=i -> out_pc 0,4,8,... one per cycle, first out_valid one cycle after release.
REQ-031 out_ready=0 for 10 cycles -> count stops at 4, FSM FULL, imem_addr holds 16; out_ready=1 -> out_pc 0,4,8,12,16 in order with no gaps.
REQ-032 redirect_valid with redirect_pc=0x47 while the queue is full -> next cycle out_valid=0 and imem_addr=0x44; the cycle after, out_pc=0x44.
REQ-033 halt_req=1 for 5 cycles with 3 entries queued and out_ready=1 -> 3 pops, then out_valid=0, imem_addr unchanged; release -> fetching resumes at the held address.
REQ-034 FETCH_BOUNDS_CHECK_EN defined, redirect to 0x3F8, MEM_BYTES=1024 -> 0x3F8 and 0x3FC delivered, fault=1 next, no further pushes; redirect to 0 resumes fetching with fault still 1.
REQ-035 reset_n low for one cycle during a simultaneous push and pop -> next cycle out_valid=0, imem_addr=RESET_PC, fault=0.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction fetch controller bus bundle:
// imem port, redirect/halt controls, decode handshake.
interface instr_fetch_ctrl_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fault;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fault
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fault
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller with prefetch queue.
// Optional bounds check: define FETCH_BOUNDS_CHECK_EN.
module instr_fetch_ctrl #(
  parameter int          DEPTH     = 4,
  parameter int          MEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input logic               clk,
  input logic               reset_n,
  instr_fetch_ctrl_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    FETCH,
    FULL,
    PAUSE
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    FAULT
`endif
  } state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        q_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_pop;
  logic [CW-1:0] count_nx;
  logic [63:0]   fetch_pc;
  state_t        state;
  state_t        state_nx;
  logic          pop;
  logic          push;
  logic          try_push;
  logic          fault_set;
  logic          redir;
  logic          halt;

  assign redir = bus.redirect_valid;
  assign halt  = bus.halt_req;

  assign bus.imem_addr = {fetch_pc[63:2], 2'b00};
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = q_mem[rd_ptr].pc;
  assign bus.out_instr = q_mem[rd_ptr].instr;

  // redirect cancels the pop; its flush wins
  assign pop = bus.out_valid
             && bus.out_ready
             && !redir;

  assign count_pop = count - CW'(pop);

  assign try_push = (state == FETCH)
                  && !halt
                  && !redir
                  && (count != FULL_CNT || pop);

`ifdef FETCH_BOUNDS_CHECK_EN
  logic oob;
  logic fault_q;

  // 65-bit add so addresses near 2^64 never wrap into range
  assign oob = ({1'b0, fetch_pc} + 65'd3)
             >= 65'(MEM_BYTES);
  assign fault_set = try_push && oob;
  assign push      = try_push && !oob;
  assign bus.fault = fault_q;

  // sticky fault: only reset clears it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign fault_set = 1'b0;
  assign push      = try_push;
  assign bus.fault = 1'b0;
`endif

  assign count_nx = count_pop + CW'(push);

  // next-state decode; redirect overrides at the end
  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH: begin
        if (halt) begin
          state_nx = PAUSE;
        end else if (fault_set) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          state_nx = FAULT;
`else
          state_nx = FETCH;
`endif
        end else if (count_nx == FULL_CNT) begin
          state_nx = FULL;
        end
      end
      FULL: begin
        if (halt) begin
          state_nx = PAUSE;
        end else if (pop) begin
          state_nx = FETCH;
        end
      end
      PAUSE: begin
        if (!halt) begin
          state_nx = (count_pop == FULL_CNT)
                   ? FULL : FETCH;
        end
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      FAULT: state_nx = FAULT;
`endif
      default: state_nx = FETCH;
    endcase
    if (redir) begin
      state_nx = halt ? PAUSE : FETCH;
    end
  end

  // state, pointers, count and fetch address
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= FETCH;
      fetch_pc <= {RESET_PC[63:2], 2'b00};
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state <= state_nx;
      if (redir) begin
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= {bus.redirect_pc[63:2], 2'b00};
      end else begin
        count <= count_nx;
        if (push) begin
          wr_ptr   <= wr_ptr + AW'(1);
          fetch_pc <= fetch_pc + 64'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  // queue storage, not reset
  always_ff @(posedge clk) begin
    if (push && reset_n) begin
      q_mem[wr_ptr] <= '{pc: fetch_pc,
                         instr: bus.imem_instr};
    end
  end

endmodule
